kb_keymap_decoder: RTL
======================

# kb_keymap_decoder

Parametrised PS/2 keyboard decoder that replaces the bank of single-key `kb_controller` instances. It sits between `ps2_rx` and the game/display logic. It tracks make/break state for NUM_KEYS programmable scan codes, including E0-extended codes. It emits held levels, press/release pulses, and an optional typematic auto-repeat pulse for the most recently pressed key.

## Interface
Parameters:
- NUM_KEYS, 6: number of tracked keys; legal range is 1 to 32.
- CODES, {6{9'h000}}: flat NUM_KEYS*9-bit key map. Slice i is CODES[9*i+8:9*i]. Bit 8 set means the code is E0-extended; bits 7:0 hold the scan code.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 ties key_rpt to 0.
- REPEAT_DELAY, 50_000_000: number of clk cycles from a press pulse to the first repeat pulse. Must be at least 1.
- REPEAT_RATE, 10_000_000: number of clk cycles between successive repeat pulses. Must be at least 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- scan_done_tick, input, 1: one-cycle strobe from ps2_rx indicating that scan_code is valid.
- scan_code, input, 8: received byte.
- key_held, output, NUM_KEYS: level; bit i is 1 while key i is down.
- key_press, output, NUM_KEYS: one-cycle pulse on the 0→1 transition of key_held[i].
- key_release, output, NUM_KEYS: one-cycle pulse on the 1→0 transition of key_held[i].
- key_rpt, output, NUM_KEYS: one-cycle auto-repeat pulse for the tracked key.
- any_held, output, 1: OR-reduction of key_held, registered.

## Operation
- Prefix FSM has states IDLE, EXT, BRK, EXT_BRK and PAUSE. It advances only on scan_done_tick.
- IDLE transitions:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → PAUSE, with the skip counter loaded to 7.
  - Any other byte is a make event with ext=0 and stays in IDLE.
- EXT transitions:
  - F0 → EXT_BRK.
  - E0 → stays in EXT.
  - Any other byte is a make event with ext=1, then → IDLE.
- BRK: the byte is a break event with ext=0, then → IDLE.
- EXT_BRK: the byte is a break event with ext=1, then → IDLE.
- PAUSE: each byte decrements the skip counter. No events are generated. When the counter reaches 0, → IDLE. This swallows the 8-byte Pause sequence.
- An event matches key i when {ext, byte} == CODES slice i. Every matching slice is updated, so duplicate map entries all track the same key.
- Unmatched events are ignored but still complete the FSM transition.
- Make event on a key with key_held=0: set held, pulse key_press, and load the repeat tracker with this key index and REPEAT_DELAY.
- Make event on a key already held (keyboard hardware typematic): no change and no pulses.
- Break event on a key with key_held=1: clear held and pulse key_release. If this key is the tracked key, the tracker goes idle.
- Break event on a key not held: ignored.
- Repeat tracker:
  - Holds one key index, a valid bit, and a down-counter of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - While valid, the counter decrements every cycle.
  - When the counter reaches 0, pulse key_rpt[tracked] and reload REPEAT_RATE.
  - A new press of another key retargets the tracker.
- Simultaneous make and break events are impossible, because there is at most one event per tick.
- If a repeat expiry and a break of the tracked key land in the same cycle, the break wins and no key_rpt is emitted.
- If a repeat expiry and a press of a different key land in the same cycle, the press wins: the tracker retargets and no key_rpt is emitted for the old key.

## Timing
- All outputs are registered.
- key_held, key_press and key_release update one cycle after the scan_done_tick that completes the event.
- any_held follows key_held by one further cycle.
- Pulse outputs are high for exactly one clk.
- The first key_rpt occurs REPEAT_DELAY cycles after the key_press cycle. Subsequent key_rpt pulses occur every REPEAT_RATE cycles.
- Reset values: every output is 0, the FSM is in IDLE, the tracker is invalid, and all counters are 0.
- A reset asserted mid-sequence (for example after E0) discards the partial prefix. It drops all held keys without generating key_release pulses.
- scan_done_tick asserted on consecutive cycles must be handled; each byte is processed independently.

## Test plan
- Map key0=9'h01C, key1=9'h175 (extended Up). Send 1C → key_held[0]=1 and key_press[0] is a single pulse. Send F0,1C → key_release[0] pulses and key_held[0]=0.
- Send E0,75 → key_held[1]=1. Send plain 75 → no change. Send E0,F0,75 → release of key1 only.
- With REPEAT_DELAY=10 and REPEAT_RATE=4, press 1C and hold for 30 cycles → key_rpt[0] at +10, +14, +18, +22 and +26 cycles. Send F0,1C → no further key_rpt.
- Press 1C, then 5A, then send a second 1C make (typematic) → no second key_press[0]. Repeat pulses continue only for 5A, and key_held=both.
- Send the Pause sequence E1,14,77,E1,F0,14,F0,77 with 14 mapped → no events and FSM back in IDLE. The next 14 is then detected as a make.
- Send E0 then assert reset. After release, send 1C → the event decodes as non-extended key0 and all other outputs are 0.

Source files
------------

// File: rtl/kb_keymap_decoder.sv
// ---------------------------------------------------------------------------
// kb_keymap_decoder
//
// Purpose:
//   Decodes the PS/2 scan-code byte stream coming from ps2_rx into make/break
//   state for NUM_KEYS programmable scan codes (including E0-extended codes).
//   It produces held levels, press/release pulses and an optional typematic
//   auto-repeat pulse for the most recently pressed key.
//
// Parameters:
//   NUM_KEYS     - number of tracked keys (1..32)
//   CODES        - flat NUM_KEYS*9-bit key map, slice i = CODES[9*i+8:9*i],
//                  bit 8 = E0-extended, bits 7:0 = scan code
//   REPEAT_EN    - 1 enables auto-repeat, 0 ties key_rpt low
//   REPEAT_DELAY - clk cycles from key_press pulse to first key_rpt (>=1)
//   REPEAT_RATE  - clk cycles between successive key_rpt pulses (>=1)
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   scan_done_tick in   one-cycle strobe, scan_code valid
//   scan_code      in   [7:0] received byte
//   key_held       out  [NUM_KEYS-1:0] level, key i is down
//   key_press      out  [NUM_KEYS-1:0] one-cycle pulse on press
//   key_release    out  [NUM_KEYS-1:0] one-cycle pulse on release
//   key_rpt        out  [NUM_KEYS-1:0] one-cycle auto-repeat pulse
//   any_held       out  OR of key_held, one cycle behind key_held
// ---------------------------------------------------------------------------
module kb_keymap_decoder #(
   parameter int                    NUM_KEYS     = 6,
   parameter logic [NUM_KEYS*9-1:0] CODES        = {6{9'h000}},
   parameter int                    REPEAT_EN    = 1,
   parameter int                    REPEAT_DELAY = 50_000_000,
   parameter int                    REPEAT_RATE  = 10_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                scan_done_tick,
   input  logic [7:0]          scan_code,
   output logic [NUM_KEYS-1:0] key_held,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_rpt,
   output logic                any_held
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = $clog2(CNT_MAX + 32'sd1);
   localparam int IDX_W   = (NUM_KEYS > 32'sd1) ? $clog2(NUM_KEYS) : 32'sd1;

   localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic             RPT_ON   = (REPEAT_EN > 32'sd0);

   // Prefix FSM states
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_EXT     = 3'd1;
   localparam logic [2:0] ST_BRK     = 3'd2;
   localparam logic [2:0] ST_EXT_BRK = 3'd3;
   localparam logic [2:0] ST_PAUSE   = 3'd4;

   localparam logic [7:0] B_E0 = 8'hE0;
   localparam logic [7:0] B_E1 = 8'hE1;
   localparam logic [7:0] B_F0 = 8'hF0;

   logic [2:0]          state_r, state_nxt_s;
   logic [2:0]          skip_r, skip_nxt_s;
   logic                ev_make_s, ev_brk_s, ev_ext_s;

   logic [NUM_KEYS-1:0] match_s, press_s, rel_s;
   logic [NUM_KEYS-1:0] held_r, held_nxt_s;
   logic [NUM_KEYS-1:0] press_r, rel_r, rpt_r, rpt_nxt_s;
   logic                any_r;

   logic                trk_valid_r, trk_valid_nxt_s;
   logic [IDX_W-1:0]    trk_idx_r, trk_idx_nxt_s, new_idx_s;
   logic [CNT_W-1:0]    trk_cnt_r, trk_cnt_nxt_s;
   logic                trk_hit_s;

   // Prefix FSM: classifies each byte as prefix, make or break event
   always_comb begin
      state_nxt_s = state_r;
      skip_nxt_s  = skip_r;
      ev_make_s   = 1'b0;
      ev_brk_s    = 1'b0;
      ev_ext_s    = 1'b0;
      if (scan_done_tick) begin
         case (state_r)
            ST_IDLE: begin
               if (scan_code == B_E0) begin
                  state_nxt_s = ST_EXT;
               end else if (scan_code == B_F0) begin
                  state_nxt_s = ST_BRK;
               end else if (scan_code == B_E1) begin
                  state_nxt_s = ST_PAUSE;
                  skip_nxt_s  = 3'd7;
               end else begin
                  ev_make_s   = 1'b1;
               end
            end
            ST_EXT: begin
               if (scan_code == B_F0) begin
                  state_nxt_s = ST_EXT_BRK;
               end else if (scan_code == B_E0) begin
                  state_nxt_s = ST_EXT;
               end else begin
                  ev_make_s   = 1'b1;
                  ev_ext_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_BRK: begin
               ev_brk_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            ST_EXT_BRK: begin
               ev_brk_s    = 1'b1;
               ev_ext_s    = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            ST_PAUSE: begin
               // E1 loaded 7; the 7th following byte ends the Pause sequence
               if (skip_r <= 3'd1) begin
                  skip_nxt_s  = 3'd0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  skip_nxt_s  = skip_r - 3'd1;
                  state_nxt_s = ST_PAUSE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               skip_nxt_s  = 3'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Key map match: every matching slice is updated, so duplicates track together
   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         match_s[i] = ({ev_ext_s, scan_code} == CODES[9*i +: 9]);
         press_s[i] = ev_make_s & match_s[i] & ~held_r[i];
         rel_s[i]   = ev_brk_s  & match_s[i] &  held_r[i];
      end
      held_nxt_s = (held_r | press_s) & ~rel_s;
   end

   // Repeat tracker: press retargets, break of tracked key idles, else count down
   always_comb begin
      new_idx_s = {IDX_W{1'b0}};
      // Descending scan so the lowest pressed index wins
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (press_s[i]) begin
            new_idx_s = IDX_W'(i);
         end else begin
            new_idx_s = new_idx_s;
         end
      end

      trk_hit_s = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if ((trk_idx_r == IDX_W'(i)) && rel_s[i]) begin
            trk_hit_s = 1'b1;
         end else begin
            trk_hit_s = trk_hit_s;
         end
      end

      trk_valid_nxt_s = trk_valid_r;
      trk_idx_nxt_s   = trk_idx_r;
      trk_cnt_nxt_s   = trk_cnt_r;
      rpt_nxt_s       = {NUM_KEYS{1'b0}};

      // Priority order makes press and break win over a coincident expiry
      if (|press_s) begin
         trk_valid_nxt_s = 1'b1;
         trk_idx_nxt_s   = new_idx_s;
         trk_cnt_nxt_s   = DELAY_LD;
      end else if (trk_valid_r && trk_hit_s) begin
         trk_valid_nxt_s = 1'b0;
         trk_cnt_nxt_s   = {CNT_W{1'b0}};
      end else if (trk_valid_r) begin
         // Expiry is detected one cycle early so the registered pulse lands
         // exactly DELAY / RATE cycles after the press / previous repeat.
         if (trk_cnt_r <= CNT_ONE) begin
            trk_cnt_nxt_s = RATE_LD;
            for (int i = 0; i < NUM_KEYS; i++) begin
               rpt_nxt_s[i] = RPT_ON & (trk_idx_r == IDX_W'(i));
            end
         end else begin
            trk_cnt_nxt_s = trk_cnt_r - CNT_ONE;
         end
      end else begin
         trk_valid_nxt_s = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         skip_r      <= 3'd0;
         held_r      <= {NUM_KEYS{1'b0}};
         press_r     <= {NUM_KEYS{1'b0}};
         rel_r       <= {NUM_KEYS{1'b0}};
         rpt_r       <= {NUM_KEYS{1'b0}};
         any_r       <= 1'b0;
         trk_valid_r <= 1'b0;
         trk_idx_r   <= {IDX_W{1'b0}};
         trk_cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         skip_r      <= skip_nxt_s;
         held_r      <= held_nxt_s;
         press_r     <= press_s;
         rel_r       <= rel_s;
         rpt_r       <= rpt_nxt_s;
         any_r       <= |held_r;
         trk_valid_r <= trk_valid_nxt_s;
         trk_idx_r   <= trk_idx_nxt_s;
         trk_cnt_r   <= trk_cnt_nxt_s;
      end
   end

   assign key_held    = held_r;
   assign key_press   = press_r;
   assign key_release = rel_r;
   assign key_rpt     = rpt_r;
   assign any_held    = any_r;

endmodule
